// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_pkg
//  Brief   : Shared constants and types for the MEM stage: load/store funct3
//            encodings and the data-memory access FSM state encoding.
//  Rev     : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Load/store size and sign encodings (RISC-V funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Data-memory access FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    // Width of a counter able to hold 0..timeout
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module  : lsu_align
//  Brief   : Combinational load/store alignment: byte enables and lane
//            replicated store data, load lane extract with sign/zero extend,
//            and misaligned-access detection.
//  Rev     : 1.0  initial release
// ============================================================================
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword lanes out of the read word
    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_load_word[7:0];
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase
        w_half = i_offset[1] ? i_load_word[31:16] : i_load_word[15:0];
    end

    // Size decode; anything not byte/halfword behaves as a full word
    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_store_data;
        o_load_data  = i_load_word;
        o_misaligned = (i_offset != 2'd0);
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be         = 4'b0001 << i_offset;
                o_wdata      = {4{i_store_data[7:0]}};
                o_misaligned = 1'b0;
                o_load_data  = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                                  : {24'd0, w_byte};
            end
            F3_H, F3_HU: begin
                o_be         = 4'b0011 << i_offset;
                o_wdata      = {2{i_store_data[15:0]}};
                o_misaligned = i_offset[0];
                o_load_data  = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                                  : {16'd0, w_half};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage
//  Brief   : EX/MEM register, req/ack data-memory access with timeout, load
//            alignment and MEM/WB register of the 5-stage RISC-V pipeline.
//            Stalls the front of the pipe while an access is outstanding.
//  Rev     : 1.0  initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResult_ex,
    input  logic [31:0] MemWriteData_ex,
    input  logic [4:0]  rdAddr_ex,
    input  logic        RegWrite_ex,
    input  logic        MemRead_ex,
    input  logic        MemWrite_ex,
    input  logic        MemToReg_ex,
    input  logic [2:0]  funct3_ex,
    output logic [31:0] ALUResult_mem,
    output logic [4:0]  rdAddr_mem,
    output logic        RegWrite_mem,
    output logic [31:0] RegWriteData_wb,
    output logic [4:0]  rdAddr_wb,
    output logic        RegWrite_wb,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        bus_err
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    // EX/MEM register
    logic [31:0] r_alu_mem;
    logic [31:0] r_sdata_mem;
    logic [4:0]  r_rd_mem;
    logic        r_regwrite_mem;
    logic        r_memread_mem;
    logic        r_memwrite_mem;
    logic        r_memtoreg_mem;
    logic [2:0]  r_f3_mem;

    // MEM/WB register
    logic [31:0] r_alu_wb;
    logic [31:0] r_load_wb;
    logic [4:0]  r_rd_wb;
    logic        r_regwrite_wb;
    logic        r_memtoreg_wb;

    // Access FSM
    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic        w_mem_op;
    logic        w_mis_raw;
    logic        w_misaligned;
    logic        w_req;
    logic        w_stall;
    logic        w_timeout;
    logic        w_aborted;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    lsu_align u_lsu_align (
        .i_funct3     (r_f3_mem),
        .i_offset     (r_alu_mem[1:0]),
        .i_store_data (r_sdata_mem),
        .i_load_word  (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_mis_raw)
    );

    // DONE is only reached through a timeout, with the aborted entry still
    // held in EX/MEM; it retires that entry once without re-issuing it. An
    // ack releases the stall in the same cycle, so EX/MEM already advances
    // and the FSM goes straight back to IDLE, letting the next op issue.
    assign w_mem_op     = r_memread_mem | r_memwrite_mem;
    assign w_misaligned = w_mem_op & w_mis_raw;
    assign w_req        = w_mem_op & ~w_mis_raw & (r_state != ST_DONE);
    assign w_stall      = w_req & ~dmem_ack;
    assign w_timeout    = w_stall & (r_cnt == C_CNT_LAST);
    assign w_aborted    = (r_state == ST_DONE);

    // EX/MEM register: advance unless the access is still outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_mem      <= '0;
            r_sdata_mem    <= '0;
            r_rd_mem       <= '0;
            r_regwrite_mem <= 1'b0;
            r_memread_mem  <= 1'b0;
            r_memwrite_mem <= 1'b0;
            r_memtoreg_mem <= 1'b0;
            r_f3_mem       <= '0;
        end else if (!w_stall) begin
            r_alu_mem      <= ALUResult_ex;
            r_sdata_mem    <= MemWriteData_ex;
            r_rd_mem       <= rdAddr_ex;
            r_regwrite_mem <= RegWrite_ex;
            r_memread_mem  <= MemRead_ex;
            r_memwrite_mem <= MemWrite_ex;
            r_memtoreg_mem <= MemToReg_ex;
            r_f3_mem       <= funct3_ex;
        end
    end

    // MEM/WB register: bubble while stalled, squash writes of failed accesses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_wb      <= '0;
            r_load_wb     <= '0;
            r_rd_wb       <= '0;
            r_regwrite_wb <= 1'b0;
            r_memtoreg_wb <= 1'b0;
        end else if (w_stall) begin
            r_rd_wb       <= '0;
            r_regwrite_wb <= 1'b0;
        end else begin
            r_alu_wb      <= r_alu_mem;
            r_load_wb     <= w_aborted ? 32'd0 : w_load_data;
            r_rd_wb       <= r_rd_mem;
            r_regwrite_wb <= r_regwrite_mem & ~w_misaligned & ~w_aborted;
            r_memtoreg_wb <= r_memtoreg_mem;
        end
    end

    // Access FSM with wait-cycle counter; r_cnt = request cycles already spent
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                    end else if (w_stall) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    if (!w_stall) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign ALUResult_mem   = r_alu_mem;
    assign rdAddr_mem      = r_rd_mem;
    assign RegWrite_mem    = r_regwrite_mem;

    assign RegWriteData_wb = r_memtoreg_wb ? r_load_wb : r_alu_wb;
    assign rdAddr_wb       = r_rd_wb;
    assign RegWrite_wb     = r_regwrite_wb;

    assign stall_mem       = w_stall;
    assign dmem_req        = w_req;
    assign dmem_we         = w_req & r_memwrite_mem;
    assign dmem_addr       = w_req ? {r_alu_mem[31:2], 2'b00} : 32'd0;
    assign dmem_be         = w_req ? w_be : 4'd0;
    assign dmem_wdata      = w_req ? w_wdata : 32'd0;

    // A reset landing on a timeout cycle aborts silently
    assign bus_err         = ~reset & (w_misaligned | w_timeout);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_stage
//  Brief   : Directed self-checking bench for mem_stage.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResult_ex, MemWriteData_ex;
    logic [4:0]  rdAddr_ex;
    logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex;
    logic [2:0]  funct3_ex;
    logic [31:0] ALUResult_mem;
    logic [4:0]  rdAddr_mem;
    logic        RegWrite_mem;
    logic [31:0] RegWriteData_wb;
    logic [4:0]  rdAddr_wb;
    logic        RegWrite_wb;
    logic        stall_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        bus_err;

    int n_total = 0;
    int n_bad   = 0;

    // access observations
    int          n_stall, n_req, n_err;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0;
    logic        we0;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .ALUResult_ex    (ALUResult_ex),
        .MemWriteData_ex (MemWriteData_ex),
        .rdAddr_ex       (rdAddr_ex),
        .RegWrite_ex     (RegWrite_ex),
        .MemRead_ex      (MemRead_ex),
        .MemWrite_ex     (MemWrite_ex),
        .MemToReg_ex     (MemToReg_ex),
        .funct3_ex       (funct3_ex),
        .ALUResult_mem   (ALUResult_mem),
        .rdAddr_mem      (rdAddr_mem),
        .RegWrite_mem    (RegWrite_mem),
        .RegWriteData_wb (RegWriteData_wb),
        .rdAddr_wb       (rdAddr_wb),
        .RegWrite_wb     (RegWrite_wb),
        .stall_mem       (stall_mem),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw, input logic m2r,
                            input logic [2:0] f3);
        ALUResult_ex    = alu;
        MemWriteData_ex = sd;
        rdAddr_ex       = rd;
        RegWrite_ex     = rw;
        MemRead_ex      = mr;
        MemWrite_ex     = mw;
        MemToReg_ex     = m2r;
        funct3_ex       = f3;
    endtask

    task automatic nop_ex();
        drive_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    // Serve the entry now in EX/MEM: ack on wait cycle ack_after (-1 = never).
    // Returns just after the edge on which the stall released.
    task automatic run_access(input int ack_after, input logic [31:0] rdata);
        logic fin;
        fin     = 1'b0;
        n_stall = 0;
        n_req   = 0;
        n_err   = 0;
        dmem_rdata = rdata;
        for (int c = 0; c < 40 && !fin; c++) begin
            dmem_ack = (c == ack_after);
            #1;
            if (c == 0) begin
                be0    = dmem_be;
                addr0  = dmem_addr;
                wdata0 = dmem_wdata;
                we0    = dmem_we;
            end
            if (stall_mem) n_stall++;
            if (dmem_req)  n_req++;
            if (bus_err)   n_err++;
            if (!stall_mem) fin = 1'b1;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
        end
        check("access_bound", fin, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        nop_ex();
        tick(); tick(); tick();

        // reset state
        check("rst_wb_data", RegWriteData_wb, 32'd0);
        check("rst_wb_rw",   RegWrite_wb, 1'b0);
        check("rst_wb_rd",   rdAddr_wb, 5'd0);
        check("rst_mem_alu", ALUResult_mem, 32'd0);
        check("rst_stall",   stall_mem, 1'b0);
        check("rst_req",     dmem_req, 1'b0);
        check("rst_berr",    bus_err, 1'b0);
        check("rst_addr",    dmem_addr, 32'd0);
        reset = 1'b0;

        // SW @0x100, ack in the request cycle
        drive_ex(32'h100, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, F3_W);
        tick();
        nop_ex();
        run_access(0, 32'd0);
        check("sw_be",    be0, 4'b1111);
        check("sw_wdata", wdata0, 32'h1234_5678);
        check("sw_addr",  addr0, 32'h100);
        check("sw_we",    we0, 1'b1);
        check("sw_stall", n_stall, 0);
        check("sw_req",   n_req, 1);
        check("sw_wb_rw", RegWrite_wb, 1'b0);
        check("sw_idle_req", dmem_req, 1'b0);

        // LB @0x103, ack after 3 wait cycles
        drive_ex(32'h103, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, F3_B);
        tick();
        check("lb_mem_alu", ALUResult_mem, 32'h103);
        check("lb_mem_rd",  rdAddr_mem, 5'd5);
        check("lb_mem_rw",  RegWrite_mem, 1'b1);
        nop_ex();
        run_access(3, 32'h80AA_BBCC);
        check("lb_stall",   n_stall, 3);
        check("lb_req",     n_req, 4);
        check("lb_addr",    addr0, 32'h100);
        check("lb_berr",    n_err, 0);
        check("lb_wb_data", RegWriteData_wb, 32'hFFFF_FF80);
        check("lb_wb_rd",   rdAddr_wb, 5'd5);
        check("lb_wb_rw",   RegWrite_wb, 1'b1);

        // LHU @0x102
        drive_ex(32'h102, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, F3_HU);
        tick();
        nop_ex();
        run_access(1, 32'h8001_0000);
        check("lhu_wb_data", RegWriteData_wb, 32'h0000_8001);
        check("lhu_stall",   n_stall, 1);

        // SH @0x102
        drive_ex(32'h102, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, F3_H);
        tick();
        nop_ex();
        run_access(0, 32'd0);
        check("sh_be",    be0, 4'b1100);
        check("sh_wdata", wdata0, 32'hBEEF_BEEF);
        check("sh_addr",  addr0, 32'h100);

        // LW @0x101 misaligned
        drive_ex(32'h101, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
        tick();
        nop_ex();
        run_access(-1, 32'hDEAD_BEEF);
        check("mis_req",    n_req, 0);
        check("mis_stall",  n_stall, 0);
        check("mis_berr",   n_err, 1);
        check("mis_wb_rw",  RegWrite_wb, 1'b0);
        check("mis_berr_after", bus_err, 1'b0);

        // Timeout: LW @0x200 never acked
        drive_ex(32'h200, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
        tick();
        nop_ex();
        run_access(-1, 32'h5555_5555);
        check("to_stall",   n_stall, 16);
        check("to_req",     n_req, 16);
        check("to_berr",    n_err, 1);
        check("to_wb_rw",   RegWrite_wb, 1'b0);
        check("to_wb_data", RegWriteData_wb, 32'd0);
        // pipe resumes with an ALU op
        drive_ex(32'h0000_CAFE, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, F3_W);
        tick();
        check("res_mem_alu", ALUResult_mem, 32'h0000_CAFE);
        nop_ex();
        tick();
        check("res_wb_data", RegWriteData_wb, 32'h0000_CAFE);
        check("res_wb_rw",   RegWrite_wb, 1'b1);
        check("res_wb_rd",   rdAddr_wb, 5'd3);

        // Back-to-back LW, LW with one wait cycle each
        drive_ex(32'h300, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
        tick();
        drive_ex(32'h304, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
        run_access(1, 32'h1111_1111);
        check("bb1_req",     n_req, 2);
        check("bb1_wb_data", RegWriteData_wb, 32'h1111_1111);
        check("bb1_wb_rd",   rdAddr_wb, 5'd10);
        nop_ex();
        run_access(1, 32'h2222_2222);
        check("bb2_req",     n_req, 2);
        check("bb2_addr",    addr0, 32'h304);
        check("bb2_wb_data", RegWriteData_wb, 32'h2222_2222);
        check("bb2_wb_rd",   rdAddr_wb, 5'd11);

        // Reset while in ACCESS
        drive_ex(32'h400, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
        tick();
        nop_ex();
        dmem_ack = 1'b0;
        tick();
        tick();
        check("pre_rst_req", dmem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_berr_now", bus_err, 1'b0);
        tick();
        check("rst_mid_req",     dmem_req, 1'b0);
        check("rst_mid_stall",   stall_mem, 1'b0);
        check("rst_mid_berr",    bus_err, 1'b0);
        check("rst_mid_mem_alu", ALUResult_mem, 32'd0);
        check("rst_mid_wb_rw",   RegWrite_wb, 1'b0);
        check("rst_mid_wb_data", RegWriteData_wb, 32'd0);
        reset = 1'b0;
        drive_ex(32'h500, 32'd0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
        tick();
        nop_ex();
        run_access(0, 32'h3333_3333);
        check("post_rst_req",     n_req, 1);
        check("post_rst_wb_data", RegWriteData_wb, 32'h3333_3333);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
